// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the loadable instruction ROM.
//   - ld_state_t    : loader FSM encoding (boot wait / load / run)
//   - INST_MEM_NUM* : default word depth of the instruction array
//   - CHIP_ENABLE, RST_ENABLE : active levels of fetch enable and reset
//   - len_is_legal  : checks a requested session length against the depth
package inst_rom_loader_pkg;

  typedef enum logic [1:0] {
    LD_BOOT_WAIT = 2'd0,
    LD_LOAD      = 2'd1,
    LD_RUN       = 2'd2
  } ld_state_t;

  localparam int   INST_MEM_NUM_LOG2 = 10;
  localparam int   INST_MEM_NUM      = 1 << INST_MEM_NUM_LOG2;
  localparam logic CHIP_ENABLE       = 1'b1;
  localparam logic RST_ENABLE        = 1'b1;

  // A session must write at least one word and no more than the array holds.
  function automatic logic len_is_legal(input logic [31:0] len, input int aw);
    return (len != 32'd0) && (len <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/inst_rom_mem.sv
// Instruction word array: one synchronous write port, one asynchronous read port.
// The array has no reset; contents survive a loader reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write word
//   raddr : read word index
//   rdata : word at raddr (combinational)
module inst_rom_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Fetch must answer in the same cycle, so the read is not registered.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Loadable instruction ROM: answers core fetches combinationally and is filled
// through a valid/ready stream. The core is held in reset unless the FSM is in RUN.
//   clk, rst                 : clock, synchronous active-high reset
//   ld_start_i, ld_len_i     : start a load session of ld_len_i words
//   ld_valid_i, ld_data_i    : load stream word
//   ld_ready_o               : stream accepts a word this cycle (LOAD only)
//   ld_done_o                : one-cycle pulse in the first RUN cycle after a load
//   ld_err_o                 : sticky flag for an illegal session length
//   cpu_rst_o                : reset to the core
//   rom_ce_i, rom_addr_i     : fetch enable and byte address
//   rom_data_o               : fetched word, 0 when not readable
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = INST_MEM_NUM_LOG2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start_i,
  input  logic [ADDR_WIDTH:0]   ld_len_i,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  output logic                  ld_ready_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o,
  output logic                  cpu_rst_o,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [DATA_WIDTH-1:0] rom_data_o
);

  localparam int LEN_WIDTH = ADDR_WIDTH + 1;

  ld_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  len_last;
  logic                  err_reg;
  logic                  done_reg;

  logic                  len_ok;
  logic                  start_legal;
  logic                  start_illegal;
  logic                  xfer;
  logic                  last_xfer;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  rd_hit;
  logic                  unused_addr_bits;

  assign len_ok        = len_is_legal(32'(ld_len_i), ADDR_WIDTH);
  assign start_legal   = ld_start_i && len_ok;
  assign start_illegal = ld_start_i && !len_ok;

  // Reset overrides the state-derived outputs, so the core stays in reset and
  // the stream is stalled during the very cycle rst is first raised.
  assign ld_ready_o = (state_reg == LD_LOAD) && (rst != RST_ENABLE);
  assign cpu_rst_o  = (state_reg != LD_RUN) || (rst == RST_ENABLE);
  assign ld_done_o  = done_reg;
  assign ld_err_o   = err_reg;

  assign xfer      = ld_valid_i && ld_ready_o;
  assign len_last  = len_reg - LEN_WIDTH'(1);
  assign last_xfer = xfer && ({1'b0, wr_ptr_reg} == len_last);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      LD_BOOT_WAIT: begin
        if (start_legal) begin
          state_next = LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (last_xfer) begin
          state_next = LD_RUN;
        end
      end
      LD_RUN: begin
        if (start_legal) begin
          state_next = LD_LOAD;
        end else if (start_illegal) begin
          state_next = LD_BOOT_WAIT;
        end
      end
      default: state_next = LD_BOOT_WAIT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_reg  <= LD_BOOT_WAIT;
      wr_ptr_reg <= '0;
      len_reg    <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_xfer;
      case (state_reg)
        LD_BOOT_WAIT, LD_RUN: begin
          if (start_legal) begin
            len_reg    <= ld_len_i;
            wr_ptr_reg <= '0;
            err_reg    <= 1'b0;
          end else if (start_illegal) begin
            err_reg <= 1'b1;
            // Leaving RUN on a bad request: old contents are no longer trusted.
            if (state_reg == LD_RUN) begin
              len_reg <= '0;
            end
          end
        end
        LD_LOAD: begin
          if (xfer) begin
            // A full-depth session ends at the top index; clear explicitly so the
            // pointer only wraps on exit from LOAD.
            wr_ptr_reg <= last_xfer ? '0 : wr_ptr_reg + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  inst_rom_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr_reg),
    .wdata (ld_data_i),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // Word index from the byte address; byte offset and high bits alias away.
  assign rd_idx           = rom_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

  assign rd_hit     = (state_reg == LD_RUN) && (rom_ce_i == CHIP_ENABLE) &&
                      ({1'b0, rd_idx} < len_reg);
  assign rom_data_o = rd_hit ? mem_rdata : '0;

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Responder end of the core's instruction-fetch interface. It receives the fetch address and chip enable from the core and returns the instruction word in the same cycle.
- Backed by a word array that is filled at boot, and on demand, through a valid/ready load stream.
- Holds the core in reset while a load is in progress and releases it when the final word has been written.
- Sits beside the CPU top in the SoC/testbench wrapper and replaces the fixed ROM.

Parameters:
- ADDR_WIDTH, 10, log2 of word depth (1024 words).
- DATA_WIDTH, 32, instruction word width (= RegBus width).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_start_i  in  1  request a new load session; sampled in BOOT_WAIT and RUN.
- ld_len_i  in  ADDR_WIDTH+1  number of words in the session; sampled with ld_start_i.
- ld_valid_i  in  1  load word valid.
- ld_data_i  in  DATA_WIDTH  load word.
- ld_ready_o  out  1  load word accepted this cycle if ld_valid_i is also high.
- ld_done_o  out  1  one-cycle pulse when the last word has been written.
- ld_err_o  out  1  sticky error: illegal ld_len_i.
- cpu_rst_o  out  1  reset to the core; high except in RUN.
- rom_ce_i  in  1  fetch chip enable from the core.
- rom_addr_i  in  32  fetch byte address.
- rom_data_o  out  DATA_WIDTH  fetched instruction, combinational from rom_addr_i and rom_ce_i.

Behaviour:
- Reset:
  - Only clk and rst are used for clocking and reset: one clock, synchronous active-high reset.
  - On rst high at an edge: state=BOOT_WAIT, wr_ptr=0, len_q=0, ld_err_o=0, ld_done_o=0.
  - cpu_rst_o=1 and ld_ready_o=0 for as long as the block is held in reset.
  - Array contents are retained, but len_q=0 forces all reads to 0.
- States:
  - BOOT_WAIT:
    - cpu_rst_o=1, ld_ready_o=0.
    - On ld_start_i with 1 <= ld_len_i <= 2^ADDR_WIDTH: len_q<=ld_len_i, wr_ptr<=0, ld_err_o<=0, go to LOAD.
    - On ld_start_i with ld_len_i=0 or ld_len_i>2^ADDR_WIDTH: ld_err_o<=1, stay in BOOT_WAIT.
  - LOAD:
    - cpu_rst_o=1, ld_ready_o=1.
    - Transfer = ld_valid_i & ld_ready_o: write mem[wr_ptr]<=ld_data_i, then wr_ptr<=wr_ptr+1.
    - On the transfer with wr_ptr==len_q-1: go to RUN and pulse ld_done_o for exactly one cycle, in the first RUN cycle.
    - ld_start_i is ignored in LOAD.
    - There is no timeout; the block waits indefinitely for ld_valid_i.
  - RUN:
    - cpu_rst_o=0, ld_ready_o=0; serve fetches.
    - A legal ld_start_i re-enters LOAD on the next edge, with cpu_rst_o=1 from that cycle.
    - An illegal ld_start_i sets ld_err_o, drops to BOOT_WAIT and asserts cpu_rst_o. Old contents are not trusted after this.
- Read path (combinational, zero latency):
  - idx = rom_addr_i[ADDR_WIDTH+1:2].
  - rom_data_o = mem[idx] when state==RUN, rom_ce_i=1 and idx<len_q; otherwise 0.
  - rom_addr_i[1:0] and bits above ADDR_WIDTH+1 are ignored, so the address space aliases.
- Boundaries:
  - len_q = 2^ADDR_WIDTH fills the whole array; wr_ptr wraps to 0 only on exit from LOAD.
  - If the done transfer and ld_start_i land in the same cycle, ld_start_i is ignored because the block is in LOAD.
  - rst mid-LOAD aborts the session; partial data is unreadable because len_q=0.
  - The read path uses state, so nothing is readable during LOAD, even for words already written.

Decomposition:
- defines.v additions:
  - state encodings LdBootWait, LdLoad, LdRun (2 bits).
  - InstMemNum/InstMemNumLog2 mapped to the parameter defaults.
  - reuse of existing ZeroWord, ChipEnable/ChipDisable, RstEnable, InstBus.
- Sub-module inst_rom_mem: single write port (clk, we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on the array.

Test Plan:
- Reset then ld_start_i with len=3, stream 0x34010001, 0x34020002, 0x00221825 with valid held high:
  - ld_ready_o is high for 3 cycles.
  - ld_done_o pulses once.
  - cpu_rst_o falls in the same cycle as ld_done_o.
  - Fetch addr 0x4 with ce=1 returns 0x34020002.
- After that load, fetch addr 0xC (idx 3 >= len 3) returns 0; fetch addr 0x0 with ce=0 returns 0; fetch addr 0x1002 aliases to idx 0 and returns 0x34010001.
- ld_start_i with len=0 and then len=1025 in BOOT_WAIT: ld_err_o=1, state stays BOOT_WAIT, ld_ready_o stays 0, cpu_rst_o stays 1.
- LOAD with len=4 and valid toggling 1,0,1,0,1,1: exactly 4 writes at idx 0..3 in order, done after the 4th transfer, and a mid-load ld_start_i pulse has no effect.
- rst asserted after 2 of 5 words: next cycle is BOOT_WAIT, cpu_rst_o=1, every fetch returns 0. A fresh len=1 load of 0xFFFFFFFF then reads back at addr 0.
- In RUN, ld_start_i with len=2: cpu_rst_o rises on the next cycle. A full load of 1024 words makes every idx readable, the last word reads at addr 0xFFC, and ld_done_o pulses once.
